// File: rtl/frame_sequencer.sv
// APU frame counter: divides CPU ticks into quarter/half-frame strobes for the
// envelope and length units, in 4-step or 5-step mode, and raises the frame IRQ.
module frame_sequencer #(
  parameter int                 CNT_W = 16,
  parameter logic [CNT_W-1:0]   STEP1 = CNT_W'(7457),
  parameter logic [CNT_W-1:0]   STEP2 = CNT_W'(14913),
  parameter logic [CNT_W-1:0]   STEP3 = CNT_W'(22371),
  parameter logic [CNT_W-1:0]   STEP4 = CNT_W'(29829),
  parameter logic [CNT_W-1:0]   STEP5 = CNT_W'(37281)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] reg_4017,
  input  logic       wr_4017,
  input  logic       irq_ack,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] frame_step
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } step_t;

  logic [CNT_W-1:0] r_count;
  step_t            r_step;
  logic             r_mode;
  logic             r_inhibit;
  logic             r_q;
  logic             r_h;
  logic             r_irq;

  logic [CNT_W-1:0] w_count_nxt;
  step_t            w_step_nxt;
  logic             w_mode_nxt;
  logic             w_inhibit_nxt;
  logic             w_q;
  logic             w_h;
  logic             w_irq_set;
  logic             w_irq_nxt;

  // Next-state and strobe decode; a $4017 write outranks any tick in the same clk
  always_comb begin
    w_count_nxt   = r_count;
    w_step_nxt    = r_step;
    w_mode_nxt    = r_mode;
    w_inhibit_nxt = r_inhibit;
    w_q           = 1'b0;
    w_h           = 1'b0;
    w_irq_set     = 1'b0;
    if (wr_4017) begin
      w_mode_nxt    = reg_4017[7];
      w_inhibit_nxt = reg_4017[6];
      w_count_nxt   = {CNT_W{1'b0}};
      w_step_nxt    = S0;
      w_q           = reg_4017[7];
      w_h           = reg_4017[7];
    end else if (tick) begin
      w_count_nxt = r_count + CNT_W'(1);
      case (r_step)
        S0: begin
          if (r_count == STEP1) begin
            w_q        = 1'b1;
            w_step_nxt = S1;
          end else begin
            w_step_nxt = S0;
          end
        end
        S1: begin
          if (r_count == STEP2) begin
            w_q        = 1'b1;
            w_h        = 1'b1;
            w_step_nxt = S2;
          end else begin
            w_step_nxt = S1;
          end
        end
        S2: begin
          if (r_count == STEP3) begin
            w_q        = 1'b1;
            w_step_nxt = S3;
          end else begin
            w_step_nxt = S2;
          end
        end
        S3: begin
          if (r_count == STEP4) begin
            if (!r_mode) begin
              w_q         = 1'b1;
              w_h         = 1'b1;
              w_irq_set   = ~r_inhibit;
              w_count_nxt = {CNT_W{1'b0}};
              w_step_nxt  = S0;
            end else begin
              w_step_nxt  = S4;
            end
          end else begin
            w_step_nxt = S3;
          end
        end
        S4: begin
          if (r_count == STEP5) begin
            w_q         = 1'b1;
            w_h         = 1'b1;
            w_count_nxt = {CNT_W{1'b0}};
            w_step_nxt  = S0;
          end else begin
            w_step_nxt = S4;
          end
        end
        default: begin
          w_count_nxt = {CNT_W{1'b0}};
          w_step_nxt  = S0;
        end
      endcase
    end else begin
      w_count_nxt = r_count;
      w_step_nxt  = r_step;
    end
  end

  // IRQ flag: a set in the same clk as an acknowledge wins
  always_comb begin
    w_irq_nxt = r_irq;
    if (w_irq_set) begin
      w_irq_nxt = 1'b1;
    end else if (irq_ack || (wr_4017 && reg_4017[6])) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= {CNT_W{1'b0}};
      r_step    <= S0;
      r_mode    <= 1'b0;
      r_inhibit <= 1'b0;
      r_q       <= 1'b0;
      r_h       <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_step    <= w_step_nxt;
      r_mode    <= w_mode_nxt;
      r_inhibit <= w_inhibit_nxt;
      r_q       <= w_q;
      r_h       <= w_h;
      r_irq     <= w_irq_nxt;
    end
  end

  assign enable_240hz = r_q;
  assign enable_120hz = r_h;
  assign frame_irq    = r_irq;
  assign frame_step   = r_step;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer with shortened step counts 3,6,9,12,15.
module tb_frame_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] reg_4017;
  logic       wr_4017;
  logic       irq_ack;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic [2:0] frame_step;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       t;
    logic       w;
    logic [7:0] d;
    logic       a;
    logic       q;
    logic       h;
    logic       irq;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  frame_sequencer #(
    .CNT_W(16),
    .STEP1(16'd3),
    .STEP2(16'd6),
    .STEP3(16'd9),
    .STEP4(16'd12),
    .STEP5(16'd15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .reg_4017     (reg_4017),
    .wr_4017      (wr_4017),
    .irq_ack      (irq_ack),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq),
    .frame_step   (frame_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic q, input logic h,
                           input logic irq, input logic [2:0] st);
    chk({nm, ".q"},    {7'd0, enable_240hz}, {7'd0, q});
    chk({nm, ".h"},    {7'd0, enable_120hz}, {7'd0, h});
    chk({nm, ".irq"},  {7'd0, frame_irq},    {7'd0, irq});
    chk({nm, ".step"}, {5'd0, frame_step},   {5'd0, st});
  endtask

  task automatic drive(input logic t, input logic w, input logic [7:0] d, input logic a);
    @(negedge clk);
    tick     = t;
    wr_4017  = w;
    reg_4017 = d;
    irq_ack  = a;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic t, input logic w, input logic [7:0] d, input logic a,
                     input logic q, input logic h, input logic irq, input logic [2:0] st);
    vec_t v;
    v.t = t; v.w = w; v.d = d; v.a = a;
    v.q = q; v.h = h; v.irq = irq; v.st = st;
    vecs.push_back(v);
  endtask

  // n plain ticks with no event expected
  task automatic idle(input int n, input logic irq, input logic [2:0] st);
    for (int i = 0; i < n; i++) add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, irq, st);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    wr_4017  = 1'b0;
    reg_4017 = 8'h00;
    irq_ack  = 1'b0;

    // 4-step, inhibit 0, from reset
    idle(3, 1'b0, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    idle(2, 1'b0, 3'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
    idle(2, 1'b0, 3'd2);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    idle(2, 1'b0, 3'd3);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    // 5-step, inhibited: immediate Q+H, IRQ cleared by the write
    add(1'b1, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    idle(3, 1'b0, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    idle(2, 1'b0, 3'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
    idle(2, 1'b0, 3'd2);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    idle(2, 1'b0, 3'd3);
    idle(1, 1'b0, 3'd4);
    idle(2, 1'b0, 3'd4);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    // back to 4-step; ack coincident with the set keeps the flag
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(3, 1'b0, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    idle(2, 1'b0, 3'd1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2);
    idle(2, 1'b0, 3'd2);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    idle(2, 1'b0, 3'd3);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
    // switch to 5-step without inhibit: flag kept until acked
    add(1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    idle(3, 1'b1, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    // write coincident with the tick at count 6 discards the step event
    idle(3, 1'b0, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);
    idle(2, 1'b0, 3'd1);
    add(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle(3, 1'b0, 3'd0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].t, vecs[i].w, vecs[i].d, vecs[i].a);
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].h, vecs[i].irq, vecs[i].st);
    end

    // tick held low at count 5, step S1
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check_all("pre_hold", 1'b0, 1'b0, 1'b0, 3'd1);
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check_all($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0, 3'd1);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check_all("post_hold5", 1'b0, 1'b0, 1'b0, 3'd1);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check_all("post_hold6", 1'b1, 1'b1, 1'b0, 3'd2);

    // async reset at count 8 in 5-step mode
    drive(1'b1, 1'b1, 8'h80, 1'b0);
    check_all("m5_wr", 1'b1, 1'b1, 1'b0, 3'd0);
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      check_all($sformatf("m5_c%0d", c), (c == 3 || c == 6), (c == 6), 1'b0,
                (c < 3) ? 3'd0 : (c < 6) ? 3'd1 : 3'd2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_all("in_rst", 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      check_all($sformatf("rel_c%0d", c), (c == 3 || c == 6 || c == 9 || c == 12),
                (c == 6 || c == 12), (c == 12),
                (c < 3) ? 3'd0 : (c < 6) ? 3'd1 : (c < 9) ? 3'd2 : (c < 12) ? 3'd3 : 3'd0);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check_all("rel_idle", 1'b0, 1'b0, 1'b1, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
